inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction fetch queue between the instruction SRAM port and the dual-issue decode stage. Accepts one fetch line of FETCH_N 32-bit instructions per cycle, discards the slots below the fetch PC's offset within the line, and stores the remaining instructions with their PCs in a circular buffer. Presents the two oldest instructions to decode each cycle, and lets decode pop 0, 1 or 2 of them. Generalises the fixed 64-bit two-slot split to any power-of-two line width, and adds buffering, backpressure and flush.

## Interface
Parameters:
- FETCH_N, default 2: instructions per fetch line; power of two, 1..8.
- DEPTH, default 16: queue entries; power of two, at least 2*FETCH_N.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  discards all queued entries and any same-cycle input.
- in_valid  in  1  a fetch line is present on in_pc/in_data.
- in_ready  out  1  queue can accept a full line this cycle.
- in_pc  in  32  fetch PC; bits [1:0] are ignored.
- in_data  in  32*FETCH_N  fetch line; slot k occupies bits [32k+31:32k].
- out_valid0  out  1  head entry valid.
- out_inst0  out  32  head instruction.
- out_pc0  out  32  head PC.
- out_valid1  out  1  second entry valid.
- out_inst1  out  32  second instruction.
- out_pc1  out  32  second PC.
- pop  in  2  entries consumed this cycle: 0, 1 or 2. Encoding 3 is treated as 2.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Line offset: off = in_pc[2 +: log2(FETCH_N)]; off is 0 when FETCH_N=1.
- Line base address: base = in_pc with bits [log2(FETCH_N)+1:0] cleared.
- A push occurs when in_valid && in_ready && !flush.
- A push writes slots off..FETCH_N-1 in ascending order at the tail.
  - Slot k is stored with PC base+4k.
  - The number of entries written is n_in = FETCH_N - off.
- in_ready = (DEPTH - count >= FETCH_N).
  - Conservative: it does not depend on the same-cycle pop, so there is no combinational path from pop to in_ready.
- Pop:
  - The effective pop is n_out = min(pop, count).
  - Popping more entries than are valid is clamped, never an underflow.
- Outputs are taken combinationally from storage at head and head+1, mod DEPTH.
  - out_valid0 = (count >= 1); out_valid1 = (count >= 2).
  - out_inst and out_pc of an invalid slot are driven to 0.
- Head and tail pointers wrap modulo DEPTH.
- Count update: count_next = count + n_in - n_out, with push and pop in the same cycle.
- Flush:
  - Next cycle, head = tail = 0 and count = 0.
  - Any same-cycle push and pop are ignored.
  - Flush has priority over everything except rst.
- Reset (asynchronous):
  - Pointers = 0, count = 0.
  - out_valid0 = out_valid1 = 0; out_inst*/out_pc* = 0.
  - in_ready = 1.
  - Storage contents need not be cleared.
- No state machine beyond the pointers and count. Overflow is impossible by construction, because of the in_ready rule.

## Timing
- Push-to-output latency is 1 cycle: a line accepted at edge t appears on out_* after edge t.
- Pop takes effect at the edge. The next entries are visible in the same cycle after that edge.
- Simultaneous push and pop on a non-empty queue:
  - Outputs advance by n_out.
  - New entries append behind the existing ones; ordering is strictly FIFO.
- Push into an empty queue with a same-cycle pop: the pop is clamped to 0, because count=0.
- rst asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion is synchronous to clk externally.
- Wrap-around: a line whose entries straddle index DEPTH-1 → 0 is written contiguously modulo DEPTH.

## Test plan
- Reset, then FETCH_N=2, DEPTH=16. Push in_pc=0xBFC00000, in_data={0x22220000,0x11110000}.
  - Next cycle: out_inst0=0x11110000 with out_pc0=0xBFC00000.
  - out_inst1=0x22220000 with out_pc1=0xBFC00004.
  - count=2.
- Misaligned fetch: push in_pc=0xBFC00004, same data.
  - count=1, out_inst0=0x22220000, out_pc0=0xBFC00004, out_valid1=0.
- Fill and backpressure: 8 aligned pushes with no pop.
  - count=16, in_ready=0; a 9th in_valid is not accepted.
  - Pop 2 → count=14, in_ready=1 the next cycle.
- Wrap with concurrent traffic: a push and a pop=2 every cycle for 20 cycles.
  - count holds at 2.
  - PCs on out_pc0 increase by 8 per cycle across the pointer wrap, in order, with no gaps.
- Flush with in_valid=1 and pop=1 in the same cycle while count=6: next cycle count=0, out_valid0=0, and the input is dropped.
- Over-pop and async reset:
  - pop=2 with count=1 → count=0.
  - Assert rst between clock edges with count=4 → count=0 and out_valid0=0 immediately.
  - Repeat with FETCH_N=4, in_pc offset 3 → exactly 1 entry enqueued.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: accepts FETCH_N-wide fetch lines, drops the slots
// below the fetch PC offset, buffers instructions with their PCs in a circular
// buffer and presents the two oldest entries to a dual-issue decode stage.
module inst_fetch_queue #(
    parameter int FETCH_N = 2,
    parameter int DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [32*FETCH_N-1:0]   in_data,
    output logic                    out_valid0,
    output logic [31:0]             out_inst0,
    output logic [31:0]             out_pc0,
    output logic                    out_valid1,
    output logic [31:0]             out_inst1,
    output logic [31:0]             out_pc1,
    input  logic [1:0]              pop,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int LOGN = (FETCH_N > 1) ? $clog2(FETCH_N) : 1;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];

    logic [LOGN-1:0] off;
    logic [31:0]     base;
    logic            push;
    logic [CW-1:0]   n_in;
    logic [CW-1:0]   n_out;
    logic [1:0]      pop_eff;
    logic [PW-1:0]   head1;

    logic            wr_en  [FETCH_N];
    logic [PW-1:0]   wr_idx [FETCH_N];
    logic [31:0]     wr_pc  [FETCH_N];

    // A single-instruction line has no offset bits in the PC.
    generate
        if (FETCH_N > 1) begin : g_off
            assign off = in_pc[2 +: LOGN];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    assign base     = in_pc & ~((32'(FETCH_N) << 2) - 32'd1);
    // Headroom check ignores the same-cycle pop to keep pop off the ready path.
    assign in_ready = (32'(DEPTH) - 32'(count_q)) >= 32'(FETCH_N);
    assign push     = in_valid && in_ready && !flush;
    assign n_in     = push ? (CW'(FETCH_N) - CW'(off)) : '0;
    assign pop_eff  = (pop == 2'd3) ? 2'd2 : pop;
    assign n_out    = (CW'(pop_eff) > count_q) ? count_q : CW'(pop_eff);
    assign head1    = head_q + PW'(1);

    // Per-slot write enable, target index and PC for the incoming line.
    always_comb begin
        for (int k = 0; k < FETCH_N; k++) begin
            wr_en[k]  = push && (k >= int'(off));
            wr_idx[k] = tail_q + PW'(k) - PW'(off);
            wr_pc[k]  = base + 32'(4 * k);
        end
    end

    // Storage write; contents are not reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_N; k++) begin
            if (wr_en[k]) begin
                inst_q[wr_idx[k]] <= in_data[32*k +: 32];
                pc_q[wr_idx[k]]   <= wr_pc[k];
            end
        end
    end

    // Next pointer and occupancy; flush wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(n_out);
            tail_d  = tail_q + PW'(n_in);
            count_d = count_q + n_in - n_out;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Head and head+1 presented to decode, zeroed when not valid.
    always_comb begin
        out_valid0 = (count_q >= CW'(1));
        out_valid1 = (count_q >= CW'(2));
        out_inst0  = out_valid0 ? inst_q[head_q] : '0;
        out_pc0    = out_valid0 ? pc_q[head_q]   : '0;
        out_inst1  = out_valid1 ? inst_q[head1]  : '0;
        out_pc1    = out_valid1 ? pc_q[head1]    : '0;
    end

    assign count = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_valid4;
    logic [31:0]  in_pc;
    logic [63:0]  in_data;
    logic [127:0] in_data4;
    logic [1:0]   pop;

    logic         in_ready, out_valid0, out_valid1;
    logic [31:0]  out_inst0, out_pc0, out_inst1, out_pc1;
    logic [4:0]   count;

    logic         in_ready4, out_valid0_4, out_valid1_4;
    logic [31:0]  out_inst0_4, out_pc0_4, out_inst1_4, out_pc1_4;
    logic [4:0]   count4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.FETCH_N(2), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data),
        .out_valid0(out_valid0), .out_inst0(out_inst0), .out_pc0(out_pc0),
        .out_valid1(out_valid1), .out_inst1(out_inst1), .out_pc1(out_pc1),
        .pop(pop), .count(count)
    );

    inst_fetch_queue #(.FETCH_N(4), .DEPTH(16)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_pc(in_pc), .in_data(in_data4),
        .out_valid0(out_valid0_4), .out_inst0(out_inst0_4), .out_pc0(out_pc0_4),
        .out_valid1(out_valid1_4), .out_inst1(out_inst1_4), .out_pc1(out_pc1_4),
        .pop(pop), .count(count4)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [63:0] data;
        logic [1:0]  pop;
        logic [4:0]  e_count;
        logic        e_v0;
        logic [31:0] e_inst0;
        logic [31:0] e_pc0;
        logic        e_v1;
        logic [31:0] e_inst1;
        logic [31:0] e_pc1;
        logic        e_ready;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        pop       = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    initial begin
        logic [31:0] exp_pc;

        rst = 1'b1;
        in_pc = '0; in_data = '0; in_data4 = '0;
        idle_inputs();
        #12;
        chk("reset_count",  32'(count),      32'd0);
        chk("reset_v0",     32'(out_valid0), 32'd0);
        chk("reset_v1",     32'(out_valid1), 32'd0);
        chk("reset_inst0",  out_inst0,       32'd0);
        chk("reset_pc0",    out_pc0,         32'd0);
        chk("reset_ready",  32'(in_ready),   32'd1);
        rst = 1'b0;

        // valid, pc, data, pop, count, v0, inst0, pc0, v1, inst1, pc1, ready
        vecs[0] = '{1'b1, 32'hBFC00000, 64'h22220000_11110000, 2'd0, 5'd2,
                    1'b1, 32'h11110000, 32'hBFC00000, 1'b1, 32'h22220000, 32'hBFC00004, 1'b1};
        vecs[1] = '{1'b1, 32'hBFC00004, 64'h22220000_11110000, 2'd2, 5'd1,
                    1'b1, 32'h22220000, 32'hBFC00004, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[2] = '{1'b0, 32'h0, 64'h0, 2'd2, 5'd0,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 32'h00001000, 64'h0000000B_0000000A, 2'd1, 5'd2,
                    1'b1, 32'h0000000A, 32'h00001000, 1'b1, 32'h0000000B, 32'h00001004, 1'b1};
        vecs[4] = '{1'b1, 32'h00001008, 64'h0000000D_0000000C, 2'd1, 5'd3,
                    1'b1, 32'h0000000B, 32'h00001004, 1'b1, 32'h0000000C, 32'h00001008, 1'b1};
        vecs[5] = '{1'b0, 32'h0, 64'h0, 2'd3, 5'd1,
                    1'b1, 32'h0000000D, 32'h0000100C, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[6] = '{1'b0, 32'h0, 64'h0, 2'd1, 5'd0,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};

        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].valid;
            in_pc    = vecs[i].pc;
            in_data  = vecs[i].data;
            pop      = vecs[i].pop;
            step();
            chk($sformatf("v%0d_count", i), 32'(count),      32'(vecs[i].e_count));
            chk($sformatf("v%0d_v0", i),    32'(out_valid0), 32'(vecs[i].e_v0));
            chk($sformatf("v%0d_inst0", i), out_inst0,       vecs[i].e_inst0);
            chk($sformatf("v%0d_pc0", i),   out_pc0,         vecs[i].e_pc0);
            chk($sformatf("v%0d_v1", i),    32'(out_valid1), 32'(vecs[i].e_v1));
            chk($sformatf("v%0d_inst1", i), out_inst1,       vecs[i].e_inst1);
            chk($sformatf("v%0d_pc1", i),   out_pc1,         vecs[i].e_pc1);
            chk($sformatf("v%0d_ready", i), 32'(in_ready),   32'(vecs[i].e_ready));
        end
        idle_inputs();

        // Fill to capacity, then a rejected line, then drain two.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h2000 + 32'(8 * i);
            in_data  = {32'hA0000000 + 32'(2 * i + 1), 32'hA0000000 + 32'(2 * i)};
            step();
        end
        chk("fill_count", 32'(count),    32'd16);
        chk("fill_ready", 32'(in_ready), 32'd0);
        in_pc   = 32'h2040;
        in_data = 64'hDEADBEEF_DEADBEEF;
        step();
        chk("full_reject_count", 32'(count), 32'd16);
        chk("full_reject_pc0",   out_pc0,    32'h2000);
        chk("full_reject_inst0", out_inst0,  32'hA0000000);
        in_valid = 1'b0;
        pop      = 2'd2;
        step();
        pop = 2'd0;
        chk("drain_count", 32'(count),    32'd14);
        chk("drain_ready", 32'(in_ready), 32'd1);
        chk("drain_pc0",   out_pc0,       32'h2008);
        chk("drain_inst0", out_inst0,     32'hA0000002);

        // Steady push + pop=2 across several pointer wraps.
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h4000;
        in_data  = {inst_of(32'h4004), inst_of(32'h4000)};
        step();
        for (int c = 0; c < 20; c++) begin
            in_pc   = 32'h4008 + 32'(8 * c);
            in_data = {inst_of(in_pc + 32'd4), inst_of(in_pc)};
            pop     = 2'd2;
            step();
            exp_pc = 32'h4008 + 32'(8 * c);
            chk($sformatf("wrap%0d_count", c), 32'(count), 32'd2);
            chk($sformatf("wrap%0d_pc0", c),   out_pc0,    exp_pc);
            chk($sformatf("wrap%0d_pc1", c),   out_pc1,    exp_pc + 32'd4);
            chk($sformatf("wrap%0d_inst0", c), out_inst0,  inst_of(exp_pc));
        end
        pop = 2'd0;

        // Grow to 6 entries, then flush with same-cycle push and pop.
        in_pc = 32'h5000; in_data = {inst_of(32'h5004), inst_of(32'h5000)};
        step();
        in_pc = 32'h5008; in_data = {inst_of(32'h500C), inst_of(32'h5008)};
        step();
        chk("preflush_count", 32'(count), 32'd6);
        flush = 1'b1;
        in_pc = 32'h6000; in_data = {inst_of(32'h6004), inst_of(32'h6000)};
        pop   = 2'd1;
        step();
        idle_inputs();
        chk("flush_count", 32'(count),      32'd0);
        chk("flush_v0",    32'(out_valid0), 32'd0);
        step();
        chk("flush_dropped_count", 32'(count),    32'd0);
        chk("flush_ready",         32'(in_ready), 32'd1);

        // Asynchronous reset between edges.
        in_valid = 1'b1;
        in_pc = 32'h7000; in_data = {inst_of(32'h7004), inst_of(32'h7000)};
        step();
        in_pc = 32'h7008; in_data = {inst_of(32'h700C), inst_of(32'h7008)};
        step();
        in_valid = 1'b0;
        chk("prereset_count", 32'(count), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count),      32'd0);
        chk("async_v0",    32'(out_valid0), 32'd0);
        chk("async_pc0",   out_pc0,         32'd0);
        chk("async_ready", 32'(in_ready),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        // FETCH_N=4: offset 3 keeps only the last slot, offset 1 keeps three.
        in_valid4 = 1'b1;
        in_pc     = 32'h300C;
        in_data4  = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
        step();
        in_valid4 = 1'b0;
        chk("n4_off3_count", 32'(count4),       32'd1);
        chk("n4_off3_inst0", out_inst0_4,       32'hD3D3D3D3);
        chk("n4_off3_pc0",   out_pc0_4,         32'h300C);
        chk("n4_off3_v1",    32'(out_valid1_4), 32'd0);
        chk("n4_off3_ready", 32'(in_ready4),    32'd1);
        in_valid4 = 1'b1;
        in_pc     = 32'h3004;
        in_data4  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        step();
        in_valid4 = 1'b0;
        chk("n4_off1_count", 32'(count4), 32'd4);
        chk("n4_off1_pc0",   out_pc0_4,   32'h300C);
        chk("n4_off1_inst1", out_inst1_4, 32'hC1C1C1C1);
        chk("n4_off1_pc1",   out_pc1_4,   32'h3004);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
